// File: rtl/hazard_controller.sv
// Hazard and forwarding sequencer for the 5-stage MIPS pipeline.
// Detects load-use and branch-compare dependencies against EX/MEM, inserts
// bubbles through a small RUN/STALL machine, freezes everything while data
// memory is busy, and keeps a sticky memory watchdog plus a stall counter.
module hazard_controller #(
  parameter int AWIDTH    = 5,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 hc_clk,
  input  logic                 hc_rst,
  input  logic                 hc_i_ce,
  input  logic [AWIDTH-1:0]    hc_i_id_addr_rs,
  input  logic [AWIDTH-1:0]    hc_i_id_addr_rt,
  input  logic                 hc_i_id_use_rt,
  input  logic                 hc_i_id_cmp,
  input  logic                 hc_i_id_redirect,
  input  logic [AWIDTH-1:0]    hc_i_ex_addr_rs,
  input  logic [AWIDTH-1:0]    hc_i_ex_addr_rt,
  input  logic [AWIDTH-1:0]    hc_i_ex_addr_rd,
  input  logic                 hc_i_ex_reg_wr,
  input  logic                 hc_i_ex_memtoreg,
  input  logic [AWIDTH-1:0]    hc_i_mem_addr_rd,
  input  logic                 hc_i_mem_reg_wr,
  input  logic                 hc_i_mem_memtoreg,
  input  logic [AWIDTH-1:0]    hc_i_wb_addr_rd,
  input  logic                 hc_i_wb_reg_wr,
  input  logic                 hc_i_mem_ready,
  output logic                 hc_o_pc_stall,
  output logic                 hc_o_ifid_stall,
  output logic                 hc_o_ifid_flush,
  output logic                 hc_o_idex_flush,
  output logic                 hc_o_freeze,
  output logic [1:0]           hc_o_fwd_a,
  output logic [1:0]           hc_o_fwd_b,
  output logic                 hc_o_fwd_id_a,
  output logic                 hc_o_fwd_id_b,
  output logic                 hc_o_timeout,
  output logic [CNT_WIDTH-1:0] hc_o_stall_cycles
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t              state;
  logic [1:0]          bub_cnt;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                active;
  logic                ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic [1:0]          need_rs, need_rt, need;
  logic                in_stall;

  // A decode source matches a producer only if it really writes a nonzero register.
  function automatic logic reg_hit(input logic wr, input logic [AWIDTH-1:0] rd,
                                   input logic [AWIDTH-1:0] src);
    return wr && (rd != '0) && (rd == src);
  endfunction

  // Bubbles owed for one decode source; an EX match is always the newest value,
  // so it dominates any MEM match on the same register.
  function automatic logic [1:0] bubble_need(input logic ex_hit, input logic ex_ld,
                                             input logic mem_hit, input logic mem_ld,
                                             input logic cmp);
    logic [1:0] n;
    n = 2'd0;
    if (ex_hit)
      n = ex_ld ? (cmp ? 2'd2 : 2'd1) : (cmp ? 2'd1 : 2'd0);
    else if (mem_hit && mem_ld && cmp)
      n = 2'd1;
    return n;
  endfunction

  // EX operand select: MEM/ALU result beats WB; loads in MEM are not yet forwardable.
  function automatic logic [1:0] ex_fwd(input logic [AWIDTH-1:0] src,
                                        input logic mem_wr, input logic mem_ld,
                                        input logic [AWIDTH-1:0] mem_rd,
                                        input logic wb_wr, input logic [AWIDTH-1:0] wb_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_wr && !mem_ld && (mem_rd != '0) && (mem_rd == src))
      sel = 2'b10;
    else if (wb_wr && (wb_rd != '0) && (wb_rd == src))
      sel = 2'b01;
    return sel;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign active     = hc_i_ce && !hc_rst;
  assign ex_hit_rs  = reg_hit(hc_i_ex_reg_wr, hc_i_ex_addr_rd, hc_i_id_addr_rs);
  assign ex_hit_rt  = hc_i_id_use_rt && reg_hit(hc_i_ex_reg_wr, hc_i_ex_addr_rd, hc_i_id_addr_rt);
  assign mem_hit_rs = reg_hit(hc_i_mem_reg_wr, hc_i_mem_addr_rd, hc_i_id_addr_rs);
  assign mem_hit_rt = hc_i_id_use_rt && reg_hit(hc_i_mem_reg_wr, hc_i_mem_addr_rd, hc_i_id_addr_rt);
  assign need_rs    = bubble_need(ex_hit_rs, hc_i_ex_memtoreg, mem_hit_rs, hc_i_mem_memtoreg, hc_i_id_cmp);
  assign need_rt    = bubble_need(ex_hit_rt, hc_i_ex_memtoreg, mem_hit_rt, hc_i_mem_memtoreg, hc_i_id_cmp);
  assign need       = (need_rs > need_rt) ? need_rs : need_rt;
  assign in_stall   = (state == STALL) || (need != 2'd0);

  // Combinational pipeline controls; freeze overrides any bubble insertion.
  always_comb begin
    hc_o_freeze     = active && !hc_i_mem_ready;
    hc_o_pc_stall   = active && (in_stall || !hc_i_mem_ready);
    hc_o_ifid_stall = hc_o_pc_stall;
    hc_o_idex_flush = active && in_stall && hc_i_mem_ready;
    hc_o_ifid_flush = active && hc_i_id_redirect && !in_stall && hc_i_mem_ready;
    hc_o_fwd_a      = 2'b00;
    hc_o_fwd_b      = 2'b00;
    hc_o_fwd_id_a   = 1'b0;
    hc_o_fwd_id_b   = 1'b0;
    if (active) begin
      hc_o_fwd_a    = ex_fwd(hc_i_ex_addr_rs, hc_i_mem_reg_wr, hc_i_mem_memtoreg,
                             hc_i_mem_addr_rd, hc_i_wb_reg_wr, hc_i_wb_addr_rd);
      hc_o_fwd_b    = ex_fwd(hc_i_ex_addr_rt, hc_i_mem_reg_wr, hc_i_mem_memtoreg,
                             hc_i_mem_addr_rd, hc_i_wb_reg_wr, hc_i_wb_addr_rd);
      hc_o_fwd_id_a = hc_i_id_cmp && !hc_i_mem_memtoreg &&
                      reg_hit(hc_i_mem_reg_wr, hc_i_mem_addr_rd, hc_i_id_addr_rs);
      hc_o_fwd_id_b = hc_i_id_cmp && !hc_i_mem_memtoreg &&
                      reg_hit(hc_i_mem_reg_wr, hc_i_mem_addr_rd, hc_i_id_addr_rt);
    end
  end

  // Bubble sequencer: a two-bubble hazard parks in STALL; freeze and ce=0 hold it.
  always_ff @(posedge hc_clk) begin
    if (hc_rst) begin
      state   <= RUN;
      bub_cnt <= 2'd0;
    end else if (hc_i_ce && hc_i_mem_ready) begin
      case (state)
        RUN: begin
          if (need == 2'd2) begin
            bub_cnt <= 2'd1;
            state   <= STALL;
          end
        end
        STALL: begin
          bub_cnt <= bub_cnt - 2'd1;
          if (bub_cnt <= 2'd1)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Memory watchdog: counts consecutive not-ready cycles, timeout is sticky until reset.
  always_ff @(posedge hc_clk) begin
    if (hc_rst) begin
      wait_cnt     <= '0;
      hc_o_timeout <= 1'b0;
    end else if (hc_i_ce) begin
      if (!hc_i_mem_ready) begin
        if (wait_cnt != WAIT_MAX)
          wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt >= WAIT_LAST)
          hc_o_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Performance counter of cycles in which the PC was held.
  always_ff @(posedge hc_clk) begin
    if (hc_rst)
      hc_o_stall_cycles <= '0;
    else if (hc_o_pc_stall)
      hc_o_stall_cycles <= sat_inc(hc_o_stall_cycles);
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_hazard_controller;

  localparam int AW   = 5;
  localparam int TO   = 16;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          hc_clk = 1'b0;
  logic          hc_rst;
  logic          hc_i_ce;
  logic [AW-1:0] hc_i_id_addr_rs, hc_i_id_addr_rt;
  logic          hc_i_id_use_rt, hc_i_id_cmp, hc_i_id_redirect;
  logic [AW-1:0] hc_i_ex_addr_rs, hc_i_ex_addr_rt, hc_i_ex_addr_rd;
  logic          hc_i_ex_reg_wr, hc_i_ex_memtoreg;
  logic [AW-1:0] hc_i_mem_addr_rd;
  logic          hc_i_mem_reg_wr, hc_i_mem_memtoreg;
  logic [AW-1:0] hc_i_wb_addr_rd;
  logic          hc_i_wb_reg_wr;
  logic          hc_i_mem_ready;
  logic          hc_o_pc_stall, hc_o_ifid_stall, hc_o_ifid_flush, hc_o_idex_flush, hc_o_freeze;
  logic [1:0]    hc_o_fwd_a, hc_o_fwd_b;
  logic          hc_o_fwd_id_a, hc_o_fwd_id_b, hc_o_timeout;
  logic [CW-1:0] hc_o_stall_cycles;

  int compared   = 0;
  int mismatched = 0;
  bit model_on   = 0;

  // Model state: bubbles still owed, consecutive not-ready count, sticky timeout, stall count.
  int m_bub = 0, m_wait = 0, m_to = 0, m_cnt = 0;

  hazard_controller #(.AWIDTH(AW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .hc_clk(hc_clk), .hc_rst(hc_rst), .hc_i_ce(hc_i_ce),
    .hc_i_id_addr_rs(hc_i_id_addr_rs), .hc_i_id_addr_rt(hc_i_id_addr_rt),
    .hc_i_id_use_rt(hc_i_id_use_rt), .hc_i_id_cmp(hc_i_id_cmp),
    .hc_i_id_redirect(hc_i_id_redirect),
    .hc_i_ex_addr_rs(hc_i_ex_addr_rs), .hc_i_ex_addr_rt(hc_i_ex_addr_rt),
    .hc_i_ex_addr_rd(hc_i_ex_addr_rd), .hc_i_ex_reg_wr(hc_i_ex_reg_wr),
    .hc_i_ex_memtoreg(hc_i_ex_memtoreg),
    .hc_i_mem_addr_rd(hc_i_mem_addr_rd), .hc_i_mem_reg_wr(hc_i_mem_reg_wr),
    .hc_i_mem_memtoreg(hc_i_mem_memtoreg),
    .hc_i_wb_addr_rd(hc_i_wb_addr_rd), .hc_i_wb_reg_wr(hc_i_wb_reg_wr),
    .hc_i_mem_ready(hc_i_mem_ready),
    .hc_o_pc_stall(hc_o_pc_stall), .hc_o_ifid_stall(hc_o_ifid_stall),
    .hc_o_ifid_flush(hc_o_ifid_flush), .hc_o_idex_flush(hc_o_idex_flush),
    .hc_o_freeze(hc_o_freeze), .hc_o_fwd_a(hc_o_fwd_a), .hc_o_fwd_b(hc_o_fwd_b),
    .hc_o_fwd_id_a(hc_o_fwd_id_a), .hc_o_fwd_id_b(hc_o_fwd_id_b),
    .hc_o_timeout(hc_o_timeout), .hc_o_stall_cycles(hc_o_stall_cycles)
  );

  always #5 hc_clk = ~hc_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bubbles a decode source needs: worst case over every producer it matches.
  function automatic int need(input logic [AW-1:0] r, input bit en);
    int n = 0;
    if (!en) return 0;
    if (hc_i_ex_reg_wr && hc_i_ex_addr_rd != 0 && hc_i_ex_addr_rd == r) begin
      if (hc_i_ex_memtoreg) n = hc_i_id_cmp ? 2 : 1;
      else                  n = hc_i_id_cmp ? 1 : 0;
    end
    if (hc_i_mem_reg_wr && hc_i_mem_addr_rd != 0 && hc_i_mem_addr_rd == r &&
        hc_i_mem_memtoreg && hc_i_id_cmp && n < 1)
      n = 1;
    return n;
  endfunction

  function automatic logic [1:0] fwd(input logic [AW-1:0] r);
    if (hc_i_mem_reg_wr && !hc_i_mem_memtoreg && hc_i_mem_addr_rd != 0 && hc_i_mem_addr_rd == r)
      return 2'b10;
    if (hc_i_wb_reg_wr && hc_i_wb_addr_rd != 0 && hc_i_wb_addr_rd == r)
      return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit fwd_id(input logic [AW-1:0] r);
    return hc_i_id_cmp && hc_i_mem_reg_wr && !hc_i_mem_memtoreg &&
           hc_i_mem_addr_rd != 0 && hc_i_mem_addr_rd == r;
  endfunction

  // Every-cycle comparison on the falling edge, then advance the model to the next edge.
  always @(negedge hc_clk) begin : cmp
    int n, nrs, nrt;
    bit act, stalled, frz, e_pc;
    if (model_on) begin
      act     = hc_i_ce && !hc_rst;
      nrs     = need(hc_i_id_addr_rs, 1'b1);
      nrt     = need(hc_i_id_addr_rt, hc_i_id_use_rt);
      n       = (nrs > nrt) ? nrs : nrt;
      stalled = (m_bub > 0) || (n > 0);
      frz     = !hc_i_mem_ready;
      e_pc    = act && (stalled || frz);
      check("m_pc_stall",   hc_o_pc_stall,   e_pc);
      check("m_ifid_stall", hc_o_ifid_stall, e_pc);
      check("m_idex_flush", hc_o_idex_flush, act && stalled && !frz);
      check("m_ifid_flush", hc_o_ifid_flush, act && hc_i_id_redirect && !stalled && !frz);
      check("m_freeze",     hc_o_freeze,     act && frz);
      check("m_fwd_a",      hc_o_fwd_a,      act ? fwd(hc_i_ex_addr_rs) : 2'b00);
      check("m_fwd_b",      hc_o_fwd_b,      act ? fwd(hc_i_ex_addr_rt) : 2'b00);
      check("m_fwd_id_a",   hc_o_fwd_id_a,   act && fwd_id(hc_i_id_addr_rs));
      check("m_fwd_id_b",   hc_o_fwd_id_b,   act && fwd_id(hc_i_id_addr_rt));
      check("m_timeout",    hc_o_timeout,    m_to);
      check("m_stall_cyc",  hc_o_stall_cycles, m_cnt);
      if (hc_rst) begin
        m_bub = 0; m_wait = 0; m_to = 0; m_cnt = 0;
      end else if (hc_i_ce) begin
        if (frz) begin
          if (m_wait < TO) m_wait++;
          if (m_wait >= TO) m_to = 1;
        end else begin
          m_wait = 0;
          if (m_bub > 0)   m_bub--;
          else if (n == 2) m_bub = 1;
        end
        if (e_pc && m_cnt < CMAX) m_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge hc_clk);
    #1;
  endtask

  task automatic clear();
    hc_rst = 0; hc_i_ce = 1; hc_i_mem_ready = 1;
    hc_i_id_addr_rs = 0; hc_i_id_addr_rt = 0; hc_i_id_use_rt = 0;
    hc_i_id_cmp = 0; hc_i_id_redirect = 0;
    hc_i_ex_addr_rs = 0; hc_i_ex_addr_rt = 0; hc_i_ex_addr_rd = 0;
    hc_i_ex_reg_wr = 0; hc_i_ex_memtoreg = 0;
    hc_i_mem_addr_rd = 0; hc_i_mem_reg_wr = 0; hc_i_mem_memtoreg = 0;
    hc_i_wb_addr_rd = 0; hc_i_wb_reg_wr = 0;
  endtask

  task automatic beq_load_hazard();
    hc_i_ex_addr_rd = 3; hc_i_ex_reg_wr = 1; hc_i_ex_memtoreg = 1;
    hc_i_id_addr_rs = 3; hc_i_id_cmp = 1;
  endtask

  initial begin
    int burst;
    clear();
    hc_rst = 1;
    tick();
    model_on = 1;
    // Hazards and forwarding candidates present while reset is held.
    hc_i_ex_addr_rd = 2; hc_i_ex_reg_wr = 1; hc_i_ex_memtoreg = 1; hc_i_id_addr_rs = 2;
    hc_i_mem_addr_rd = 4; hc_i_mem_reg_wr = 1; hc_i_ex_addr_rs = 4;
    #2;
    check("rst_pc_stall", hc_o_pc_stall, 0);
    check("rst_fwd_a", hc_o_fwd_a, 0);
    check("rst_stall_cycles", hc_o_stall_cycles, 0);
    check("rst_timeout", hc_o_timeout, 0);

    // Load-use: one bubble, then MEM load not forwarded, then WB forward.
    tick(); clear();
    hc_i_ex_addr_rd = 2; hc_i_ex_reg_wr = 1; hc_i_ex_memtoreg = 1; hc_i_id_addr_rs = 2;
    #2;
    check("lu_pc_stall", hc_o_pc_stall, 1);
    check("lu_ifid_stall", hc_o_ifid_stall, 1);
    check("lu_idex_flush", hc_o_idex_flush, 1);
    tick(); clear();
    hc_i_mem_addr_rd = 2; hc_i_mem_reg_wr = 1; hc_i_mem_memtoreg = 1;
    hc_i_ex_addr_rs = 2; hc_i_ex_addr_rd = 5; hc_i_ex_reg_wr = 1;
    #2;
    check("lu_mem_pc_stall", hc_o_pc_stall, 0);
    check("lu_mem_fwd_a", hc_o_fwd_a, 2'b00);
    check("lu_stall_cycles", hc_o_stall_cycles, 1);
    tick(); clear();
    hc_i_wb_addr_rd = 2; hc_i_wb_reg_wr = 1; hc_i_ex_addr_rs = 2;
    hc_i_mem_addr_rd = 5; hc_i_mem_reg_wr = 1;
    #2;
    check("lu_wb_fwd_a", hc_o_fwd_a, 2'b01);

    // Load feeding a branch compare: exactly two stall cycles.
    tick(); clear(); beq_load_hazard(); #2;
    check("beq_c1_pc_stall", hc_o_pc_stall, 1);
    tick(); clear(); #2;
    check("beq_c2_pc_stall", hc_o_pc_stall, 1);
    check("beq_c2_idex_flush", hc_o_idex_flush, 1);
    tick(); clear(); #2;
    check("beq_c3_pc_stall", hc_o_pc_stall, 0);
    check("beq_stall_cycles", hc_o_stall_cycles, 3);

    // Forwarding priority and the $0 exclusion.
    tick(); clear();
    hc_i_mem_addr_rd = 4; hc_i_mem_reg_wr = 1; hc_i_wb_addr_rd = 4; hc_i_wb_reg_wr = 1;
    hc_i_ex_addr_rs = 4; hc_i_ex_addr_rt = 4; hc_i_id_addr_rs = 4; hc_i_id_cmp = 1;
    #2;
    check("prio_fwd_a", hc_o_fwd_a, 2'b10);
    check("prio_fwd_b", hc_o_fwd_b, 2'b10);
    check("prio_fwd_id_a", hc_o_fwd_id_a, 1);
    check("prio_pc_stall", hc_o_pc_stall, 0);
    tick(); clear();
    hc_i_ex_reg_wr = 1; hc_i_mem_reg_wr = 1; hc_i_wb_reg_wr = 1;
    #2;
    check("r0_fwd_a", hc_o_fwd_a, 2'b00);
    check("r0_pc_stall", hc_o_pc_stall, 0);

    // Freeze in the middle of a two-bubble stall.
    tick(); clear(); beq_load_hazard(); #2;
    check("fz_c1_pc_stall", hc_o_pc_stall, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); clear(); hc_i_mem_ready = 0; #2;
      check("fz_freeze", hc_o_freeze, 1);
      check("fz_idex_flush", hc_o_idex_flush, 0);
    end
    tick(); clear(); #2;
    check("fz_resume_pc_stall", hc_o_pc_stall, 1);
    check("fz_resume_idex_flush", hc_o_idex_flush, 1);
    tick(); clear(); #2;
    check("fz_done_pc_stall", hc_o_pc_stall, 0);
    check("fz_stall_cycles", hc_o_stall_cycles, 8);

    // Redirect acted on only when not stalled.
    tick(); clear(); hc_i_id_redirect = 1; #2;
    check("redir_flush", hc_o_ifid_flush, 1);
    tick(); clear(); hc_i_id_redirect = 1;
    hc_i_ex_addr_rd = 2; hc_i_ex_reg_wr = 1; hc_i_ex_memtoreg = 1; hc_i_id_addr_rs = 2;
    #2;
    check("redir_stalled_flush", hc_o_ifid_flush, 0);

    // Watchdog: sets after sixteen not-ready cycles and stays set.
    for (int i = 0; i < TO; i++) begin
      tick(); clear(); hc_i_mem_ready = 0; #2;
      check("wd_before", hc_o_timeout, 0);
    end
    tick(); clear(); #2;
    check("wd_set", hc_o_timeout, 1);
    tick(); #2;
    check("wd_sticky", hc_o_timeout, 1);

    // Reset while parked in STALL drops the owed bubble.
    tick(); clear(); beq_load_hazard(); #2;
    tick(); clear(); hc_rst = 1; #2;
    check("rstst_pc_stall", hc_o_pc_stall, 0);
    tick(); clear(); #2;
    check("rstst_after_pc_stall", hc_o_pc_stall, 0);
    check("rstst_idex_flush", hc_o_idex_flush, 0);
    check("rstst_stall_cycles", hc_o_stall_cycles, 0);
    check("rstst_timeout", hc_o_timeout, 0);

    // Randomized traffic on a small register window to provoke frequent matches.
    burst = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      hc_rst            = ($urandom % 300) == 0;
      hc_i_ce           = ($urandom % 8) != 0;
      hc_i_id_addr_rs   = AW'($urandom_range(0, 3));
      hc_i_id_addr_rt   = AW'($urandom_range(0, 3));
      hc_i_id_use_rt    = $urandom % 2;
      hc_i_id_cmp       = $urandom % 2;
      hc_i_id_redirect  = ($urandom % 4) == 0;
      hc_i_ex_addr_rs   = AW'($urandom_range(0, 3));
      hc_i_ex_addr_rt   = AW'($urandom_range(0, 3));
      hc_i_ex_addr_rd   = AW'($urandom_range(0, 3));
      hc_i_ex_reg_wr    = $urandom % 2;
      hc_i_ex_memtoreg  = $urandom % 2;
      hc_i_mem_addr_rd  = AW'($urandom_range(0, 3));
      hc_i_mem_reg_wr   = $urandom % 2;
      hc_i_mem_memtoreg = $urandom % 2;
      hc_i_wb_addr_rd   = AW'($urandom_range(0, 3));
      hc_i_wb_reg_wr    = $urandom % 2;
      if (burst > 0) begin
        hc_i_mem_ready = 0;
        burst--;
      end else begin
        if (($urandom % 60) == 0) burst = $urandom_range(1, 20);
        hc_i_mem_ready = ($urandom % 10) != 0;
      end
    end
    tick(); clear();
    @(negedge hc_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
